matrix_input_writer: RTL and testbench

//  Write-side master for matrix storage. Takes a stream of parsed signed integers from the input front end.
//  The stream is: rows, cols, then the elements in row-major order. The block checks the stream and issues a
//  set_dims command followed by single-element write commands to matrix storage. It sits between the

---
 rtl/matrix_input_writer_if.sv | 37 +++
 rtl/matrix_input_writer.sv | 187 ++++++++++++++++++
 tb/tb_matrix_input_writer.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_input_writer_if.sv
// Handshake and storage-write bundle between the number parser, the writer and matrix storage.
// The master side is the writer block; the slave side is whoever drives the token stream and control.
interface matrix_input_writer_if #(
   parameter int DIM_W  = 3,
   parameter int ELEM_W = 8
);
   logic                     start;
   logic                     abort;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [ELEM_W-1:0] in_data;
   logic                     in_last;
   logic                     wr_en;
   logic                     wr_cmd_set_dims;
   logic                     wr_cmd_single;
   logic [DIM_W-1:0]         wr_dims_r;
   logic [DIM_W-1:0]         wr_dims_c;
   logic [DIM_W-1:0]         wr_row_idx;
   logic [DIM_W-1:0]         wr_col_idx;
   logic signed [ELEM_W-1:0] wr_val_scalar;
   logic                     busy;
   logic                     done;
   logic                     err;
   logic [1:0]               err_code;

   modport master (
      input  start, abort, in_valid, in_data, in_last,
      output in_ready, wr_en, wr_cmd_set_dims, wr_cmd_single, wr_dims_r, wr_dims_c,
             wr_row_idx, wr_col_idx, wr_val_scalar, busy, done, err, err_code
   );

   modport slave (
      output start, abort, in_valid, in_data, in_last,
      input  in_ready, wr_en, wr_cmd_set_dims, wr_cmd_single, wr_dims_r, wr_dims_c,
             wr_row_idx, wr_col_idx, wr_val_scalar, busy, done, err, err_code
   );
endinterface

// File: rtl/matrix_input_writer.sv
// Turns a rows/cols/elements token stream into one set_dims command plus single-element writes,
// validating dimensions and element range; every output is a flop.
module matrix_input_writer #(
   parameter int ROW_MAX  = 5,
   parameter int COL_MAX  = 5,
   parameter int DIM_W    = 3,
   parameter int ELEM_W   = 8,
   parameter int ELEM_MIN = 0,
   parameter int ELEM_MAX = 9
) (
   input logic                   clk,
   input logic                   rst_n,
   matrix_input_writer_if.master bus
);

   typedef enum logic [2:0] {IDLE, GET_R, GET_C, SET_DIMS, GET_E, DONE, ERR} state_e;

   state_e            state_q, state_d;
   logic [DIM_W-1:0]  rows_q, rows_d, cols_q, cols_d;
   logic [DIM_W-1:0]  row_q, row_d, col_q, col_d;
   logic              in_ready_q, in_ready_d, busy_q, busy_d;
   logic              wr_en_q, wr_en_d, set_dims_q, set_dims_d, single_q, single_d;
   logic [DIM_W-1:0]  dims_r_q, dims_r_d, dims_c_q, dims_c_d;
   logic [DIM_W-1:0]  row_idx_q, row_idx_d, col_idx_q, col_idx_d;
   logic [ELEM_W-1:0] val_q, val_d;
   logic              done_q, done_d, err_q, err_d;
   logic [1:0]        err_code_q, err_code_d;
   int                tok_v;
   logic              accept, last_cell;

   assign tok_v     = int'(bus.in_data);
   assign accept    = bus.in_valid & in_ready_q;
   assign last_cell = (row_q == rows_q - DIM_W'(1)) && (col_q == cols_q - DIM_W'(1));

   // NOTE: every variable gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      rows_d     = rows_q;
      cols_d     = cols_q;
      row_d      = row_q;
      col_d      = col_q;
      err_code_d = err_code_q;
      wr_en_d    = 1'b0;
      set_dims_d = 1'b0;
      single_d   = 1'b0;
      dims_r_d   = '0;
      dims_c_d   = '0;
      row_idx_d  = '0;
      col_idx_d  = '0;
      val_d      = '0;
      done_d     = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         IDLE: if (bus.start) begin
            state_d    = GET_R;
            err_code_d = 2'd0;
            row_d      = '0;
            col_d      = '0;
         end
         GET_R: if (accept) begin
            if (tok_v < 1 || tok_v > ROW_MAX) begin
               state_d = ERR; err_code_d = 2'd1;
            end else if (bus.in_last) begin
               state_d = ERR; err_code_d = 2'd2;
            end else begin
               state_d = GET_C; rows_d = DIM_W'(tok_v);
            end
         end
         GET_C: if (accept) begin
            if (tok_v < 1 || tok_v > COL_MAX) begin
               state_d = ERR; err_code_d = 2'd1;
            end else if (bus.in_last) begin
               state_d = ERR; err_code_d = 2'd2;
            end else begin
               // Command is registered, so it is presented during the SET_DIMS cycle itself.
               state_d    = SET_DIMS;
               cols_d     = DIM_W'(tok_v);
               wr_en_d    = 1'b1;
               set_dims_d = 1'b1;
               dims_r_d   = rows_q;
               dims_c_d   = DIM_W'(tok_v);
            end
         end
         SET_DIMS: state_d = GET_E;
         GET_E: if (accept) begin
            if (tok_v < ELEM_MIN || tok_v > ELEM_MAX) begin
               state_d = ERR; err_code_d = 2'd3;
            end else begin
               wr_en_d   = 1'b1;
               single_d  = 1'b1;
               row_idx_d = row_q;
               col_idx_d = col_q;
               val_d     = bus.in_data;
               if (col_q == cols_q - DIM_W'(1)) begin
                  col_d = '0;
                  row_d = row_q + DIM_W'(1);
               end else begin
                  col_d = col_q + DIM_W'(1);
               end
               if (last_cell || bus.in_last) state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         ERR: begin
            state_d = IDLE;
            err_d   = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // Abort overrides whatever the current state decided, including pending writes and pulses.
      if (bus.abort && state_q != IDLE) begin
         state_d    = IDLE;
         err_code_d = err_code_q;
         wr_en_d    = 1'b0;
         set_dims_d = 1'b0;
         single_d   = 1'b0;
         done_d     = 1'b0;
         err_d      = 1'b0;
      end

      busy_d     = (state_d != IDLE);
      in_ready_d = (state_d == GET_R) || (state_d == GET_C) || (state_d == GET_E);
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rows_q     <= '0;
         cols_q     <= '0;
         row_q      <= '0;
         col_q      <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         wr_en_q    <= 1'b0;
         set_dims_q <= 1'b0;
         single_q   <= 1'b0;
         dims_r_q   <= '0;
         dims_c_q   <= '0;
         row_idx_q  <= '0;
         col_idx_q  <= '0;
         val_q      <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         rows_q     <= rows_d;
         cols_q     <= cols_d;
         row_q      <= row_d;
         col_q      <= col_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
         wr_en_q    <= wr_en_d;
         set_dims_q <= set_dims_d;
         single_q   <= single_d;
         dims_r_q   <= dims_r_d;
         dims_c_q   <= dims_c_d;
         row_idx_q  <= row_idx_d;
         col_idx_q  <= col_idx_d;
         val_q      <= val_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   assign bus.in_ready        = in_ready_q;
   assign bus.busy            = busy_q;
   assign bus.wr_en           = wr_en_q;
   assign bus.wr_cmd_set_dims = set_dims_q;
   assign bus.wr_cmd_single   = single_q;
   assign bus.wr_dims_r       = dims_r_q;
   assign bus.wr_dims_c       = dims_c_q;
   assign bus.wr_row_idx      = row_idx_q;
   assign bus.wr_col_idx      = col_idx_q;
   assign bus.wr_val_scalar   = val_q;
   assign bus.done            = done_q;
   assign bus.err             = err_q;
   assign bus.err_code        = err_code_q;

endmodule

// File: tb/tb_matrix_input_writer.sv
// Bench for matrix_input_writer: directed scenarios plus randomized entries, each compared against
// a stream-level reference model that renders the expected command trace as a string.
module tb_matrix_input_writer;
   localparam int ROW_MAX  = 5;
   localparam int COL_MAX  = 5;
   localparam int DIM_W    = 3;
   localparam int ELEM_W   = 8;
   localparam int ELEM_MIN = 0;
   localparam int ELEM_MAX = 9;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   matrix_input_writer_if #(.DIM_W(DIM_W), .ELEM_W(ELEM_W)) bus ();

   matrix_input_writer #(
      .ROW_MAX(ROW_MAX), .COL_MAX(COL_MAX), .DIM_W(DIM_W), .ELEM_W(ELEM_W),
      .ELEM_MIN(ELEM_MIN), .ELEM_MAX(ELEM_MAX)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.master)
   );

   int    tests_run = 0;
   int    tests_failed = 0;
   int    cyc = 0;
   string obs = "";
   int    wr_cyc[$];
   int    end_cyc = 0;
   bit    end_seen = 1'b0;
   int    bad_proto = 0;
   int    tok_q[$];
   bit    last_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Observed trace: D<r><c> for set_dims, W<r><c>=<v> per element write, DONE, E<code>.
   always @(negedge clk) begin
      if (bus.wr_en) begin
         if (bus.wr_cmd_set_dims && !bus.wr_cmd_single)
            obs = {obs, $sformatf("D%0d%0d ", bus.wr_dims_r, bus.wr_dims_c)};
         else if (bus.wr_cmd_single && !bus.wr_cmd_set_dims) begin
            obs = {obs, $sformatf("W%0d%0d=%0d ", bus.wr_row_idx, bus.wr_col_idx, bus.wr_val_scalar)};
            wr_cyc.push_back(cyc);
         end else
            bad_proto++;
      end else if (bus.wr_cmd_set_dims || bus.wr_cmd_single)
         bad_proto++;
      if (bus.done) begin obs = {obs, "DONE "}; end_seen = 1'b1; end_cyc = cyc; end
      if (bus.err)  begin obs = {obs, $sformatf("E%0d ", bus.err_code)}; end_seen = 1'b1; end_cyc = cyc; end
   end

   // Reference: walk the token list by the stream rules and list what storage should see.
   function automatic string model_trace();
      string s;
      int r, c, v;
      r = tok_q[0];
      if (r < 1 || r > ROW_MAX) return "E1 ";
      if (last_q[0]) return "E2 ";
      c = tok_q[1];
      if (c < 1 || c > COL_MAX) return "E1 ";
      if (last_q[1]) return "E2 ";
      s = $sformatf("D%0d%0d ", r, c);
      for (int k = 0; k < r * c; k++) begin
         v = tok_q[2 + k];
         if (v < ELEM_MIN || v > ELEM_MAX) return {s, "E3 "};
         s = {s, $sformatf("W%0d%0d=%0d ", k / c, k % c, v)};
         if (last_q[2 + k]) break;
      end
      return {s, "DONE "};
   endfunction

   task automatic set_tokens(input int vals[$], input int last_at);
      tok_q.delete();
      last_q.delete();
      foreach (vals[i]) begin
         tok_q.push_back(vals[i]);
         last_q.push_back(i == last_at);
      end
   endtask

   task automatic clear_obs();
      obs = "";
      wr_cyc.delete();
      end_seen = 1'b0;
   endtask

   task automatic do_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // gap_mode: 0 = valid held, 1 = valid toggles 1-0-1, 2 = random gaps.
   task automatic drive_entry(input int gap_mode, input bit wait_end);
      int idx;
      int n;
      bit give, acc;
      idx = 0;
      n = 0;
      while (idx < tok_q.size() && !end_seen && n < 400) begin
         give = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (n % 2 == 0) : 1'($urandom_range(0, 1));
         bus.in_valid = give;
         bus.in_data  = ELEM_W'(tok_q[idx]);
         bus.in_last  = last_q[idx];
         acc = give && bus.in_ready;
         @(negedge clk);
         if (acc) idx++;
         n++;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      if (wait_end) begin
         for (int k = 0; k < 60 && !end_seen; k++) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      tests_run++;
      if ({bus.busy, bus.in_ready, bus.wr_en, bus.wr_cmd_set_dims, bus.wr_cmd_single, bus.done, bus.err,
           bus.err_code, bus.wr_dims_r, bus.wr_dims_c, bus.wr_row_idx, bus.wr_col_idx, bus.wr_val_scalar} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: busy=%b in_ready=%b wr_en=%b err_code=%0d, required all zero",
                  bus.busy, bus.in_ready, bus.wr_en, bus.err_code);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if (bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_after_reset: busy=%b, required 0", bus.busy);
      end
   endtask

   task automatic test_basic();
      string exp;
      set_tokens('{2, 3, 1, 2, 3, 4, 5, 6}, -1);
      exp = model_trace();
      clear_obs();
      do_start();
      drive_entry(0, 1'b1);
      tests_run++;
      if (obs != exp) begin
         tests_failed++;
         $display("FAIL basic_trace: got '%s', required '%s'", obs, exp);
      end
      tests_run++;
      if (wr_cyc.size() != 6 || wr_cyc[5] - wr_cyc[0] != 5) begin
         tests_failed++;
         $display("FAIL basic_consecutive: %0d writes over %0d cycles, required 6 over 5",
                  wr_cyc.size(), (wr_cyc.size() > 0) ? wr_cyc[$] - wr_cyc[0] : -1);
      end
      tests_run++;
      if (wr_cyc.size() == 0 || end_cyc != wr_cyc[$] + 1) begin
         tests_failed++;
         $display("FAIL basic_done_timing: done cycle %0d, required %0d", end_cyc,
                  (wr_cyc.size() > 0) ? wr_cyc[$] + 1 : -1);
      end
      tests_run++;
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_idle_after: in_ready=%b busy=%b, required 0 0", bus.in_ready, bus.busy);
      end
   endtask

   task automatic test_bad_dims();
      string exp;
      set_tokens('{6, 2, 1}, -1);
      exp = model_trace();
      clear_obs();
      do_start();
      drive_entry(0, 1'b1);
      tests_run++;
      if (obs != exp) begin
         tests_failed++;
         $display("FAIL rows_too_big: got '%s', required '%s'", obs, exp);
      end
      @(negedge clk);
      tests_run++;
      if (bus.err_code !== 2'd1) begin
         tests_failed++;
         $display("FAIL err_code_held: got %0d, required 1", bus.err_code);
      end
      clear_obs();
      do_start();
      tests_run++;
      if (bus.err_code !== 2'd0 || bus.busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL start_clears_code: err_code=%0d busy=%b, required 0 1", bus.err_code, bus.busy);
      end
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (obs != "" || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_in_get_r: trace '%s' busy=%b, required empty 0", obs, bus.busy);
      end
      for (int t = 0; t < 3; t++) begin
         case (t)
            0: set_tokens('{3, 2}, 0);
            1: set_tokens('{2, 0, 1}, -1);
            default: set_tokens('{2, 3, 1}, 1);
         endcase
         exp = model_trace();
         clear_obs();
         do_start();
         drive_entry(0, 1'b1);
         tests_run++;
         if (obs != exp) begin
            tests_failed++;
            $display("FAIL dims_case%0d: got '%s', required '%s'", t, obs, exp);
         end
      end
   endtask

   task automatic test_early_last();
      string exp;
      set_tokens('{2, 2, 7, 8, 9}, 4);
      exp = model_trace();
      clear_obs();
      do_start();
      drive_entry(0, 1'b1);
      tests_run++;
      if (obs != exp) begin
         tests_failed++;
         $display("FAIL early_last: got '%s', required '%s'", obs, exp);
      end
   endtask

   task automatic test_gaps();
      string exp;
      set_tokens('{3, 3, 1, 2, 3, 4, 5, 6, 7, 8, 9}, -1);
      exp = model_trace();
      clear_obs();
      do_start();
      drive_entry(1, 1'b1);
      tests_run++;
      if (obs != exp || wr_cyc.size() != 9) begin
         tests_failed++;
         $display("FAIL gap_stream: got '%s' (%0d writes), required '%s' (9 writes)", obs, wr_cyc.size(), exp);
      end
   endtask

   task automatic test_bad_elem();
      string exp;
      for (int t = 0; t < 2; t++) begin
         if (t == 0) set_tokens('{2, 2, 4, 10, 3}, -1);
         else        set_tokens('{2, 2, -1, 3}, -1);
         exp = model_trace();
         clear_obs();
         do_start();
         drive_entry(0, 1'b1);
         tests_run++;
         if (obs != exp || bus.err_code !== 2'd3) begin
            tests_failed++;
            $display("FAIL bad_elem%0d: got '%s' code %0d, required '%s' code 3", t, obs, bus.err_code, exp);
         end
      end
   endtask

   task automatic test_abort_and_reset();
      set_tokens('{3, 1, 5}, -1);
      clear_obs();
      do_start();
      drive_entry(0, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'sd6;
      bus.abort    = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.abort    = 1'b0;
      tests_run++;
      if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_next_cycle: busy=%b wr_en=%b, required 0 0", bus.busy, bus.wr_en);
      end
      repeat (4) @(negedge clk);
      tests_run++;
      if (obs != "D31 W00=5 ") begin
         tests_failed++;
         $display("FAIL abort_trace: got '%s', required 'D31 W00=5 '", obs);
      end

      set_tokens('{2, 2, 4}, -1);
      clear_obs();
      do_start();
      drive_entry(0, 1'b0);
      tests_run++;
      if (bus.wr_en !== 1'b1 || bus.busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL pre_reset_write: wr_en=%b busy=%b, required 1 1", bus.wr_en, bus.busy);
      end
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({bus.busy, bus.in_ready, bus.wr_en, bus.wr_cmd_set_dims, bus.wr_cmd_single, bus.done, bus.err,
           bus.err_code, bus.wr_row_idx, bus.wr_col_idx, bus.wr_val_scalar} !== '0) begin
         tests_failed++;
         $display("FAIL async_reset: busy=%b wr_en=%b single=%b val=%0d, required all zero",
                  bus.busy, bus.wr_en, bus.wr_cmd_single, bus.wr_val_scalar);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++;
      if (obs != "D22 W00=4 " || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL after_reset: trace '%s' busy=%b, required 'D22 W00=4 ' 0", obs, bus.busy);
      end
   endtask

   task automatic test_random();
      string exp;
      int r, c, n;
      int vals[$];
      for (int e = 0; e < 40; e++) begin
         vals.delete();
         r = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, ROW_MAX)) : (($urandom_range(0, 1) == 1) ? 0 : 6);
         c = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, COL_MAX)) : (($urandom_range(0, 1) == 1) ? -1 : 7);
         vals.push_back(r);
         vals.push_back(c);
         n = (r >= 1 && r <= ROW_MAX && c >= 1 && c <= COL_MAX) ? r * c : 2;
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 24) == 0) vals.push_back(($urandom_range(0, 1) == 1) ? -2 : 12);
            else vals.push_back(int'($urandom_range(ELEM_MIN, ELEM_MAX)));
         end
         set_tokens(vals, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, vals.size() - 1)) : -1);
         exp = model_trace();
         clear_obs();
         do_start();
         drive_entry(2 * int'($urandom_range(0, 1)), 1'b1);
         tests_run++;
         if (obs != exp || !end_seen) begin
            tests_failed++;
            $display("FAIL random_entry%0d: got '%s', required '%s'", e, obs, exp);
         end
      end
      tests_run++;
      if (bad_proto != 0) begin
         tests_failed++;
         $display("FAIL command_exclusive: %0d bad strobe cycles, required 0", bad_proto);
      end
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.abort    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      test_reset();
      test_basic();
      test_bad_dims();
      test_early_last();
      test_gaps();
      test_bad_elem();
      test_abort_and_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
